mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between the RISC5 pipe's instruction-fetch requester and its load/store requester.
- Performs priority/fairness arbitration and latches each request for the duration of the memory transaction.
- Sequences the memory strobe/acknowledge handshake and returns the read data to the granted requester.
- Guards against a hung memory with a timeout that reports a bus error to the test harness.

Parameters:
ADDR_W, 24, byte address width of both requesters and the memory port
DATA_W, 32, data word width
TIMEOUT, 15, cycles in BUSY without mem_ack before the transaction is aborted (valid range 1..255)

Ports:
clk  in  1  system clock, 100 MHz, all state on rising edge
rst  in  1  synchronous reset, active high
i_stb  in  1  fetch request; held until i_ack
i_addr  in  ADDR_W  fetch address
i_ack  out  1  one-cycle fetch completion pulse
i_rdata  out  DATA_W  fetch data, valid while i_ack=1
d_stb  in  1  data request; held until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  DATA_W  load data, valid while d_ack=1
mem_stb  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle
mem_rdata  in  DATA_W  memory read data
bus_err  out  1  sticky: set on any timeout, cleared only by rst

Behaviour:
- Reset: all outputs 0; state=IDLE; last_grant=I; timeout counter=0. A reset mid-transaction aborts it with no ack.
- States: IDLE, BUSY, DONE.
- IDLE, no stb: stay in IDLE.
- IDLE, one stb: grant that requester.
- IDLE, both stbs: grant D, unless last_grant=D, then grant I. Consecutive data requests therefore alternate with a pending fetch; a fetch never waits longer than one data transaction.
- On grant: latch addr/we/wdata into the mem_* registers (mem_we=0 for fetch), set mem_stb=1 next cycle, record last_grant, go to BUSY.
- BUSY, mem_ack=1: latch mem_rdata, clear mem_stb and mem_we next cycle, go to DONE.
- BUSY, mem_ack=0: increment the counter.
- BUSY, counter reaches TIMEOUT: abort. mem_stb=0; latched rdata=0; bus_err=1; go to DONE.
- DONE: pulse the granted requester's ack for exactly one cycle with the latched rdata; clear the counter; go to IDLE.
- The requester drops stb on the edge that samples ack. The DONE cycle ensures the still-high stb is not re-granted.
- i_rdata/d_rdata are driven only during their ack cycle and are 0 otherwise.
- Minimum latency with zero-wait memory (mem_ack in the first BUSY cycle): stb seen in cycle 0, mem_stb in cycle 1, ack in cycle 2, back in IDLE in cycle 3. Throughput is one transaction per 3 cycles.
- mem_ack outside BUSY is ignored.
- stb changes while BUSY/DONE have no effect on the active transaction (fields are latched).
- Writes return d_ack with d_rdata = whatever the memory drove.

Test Plan:
- Single fetch, i_addr=0x000100, zero-wait memory returning 0xDEADBEEF: mem_stb in cycle 1 with mem_addr=0x000100 and mem_we=0; i_ack=1 with i_rdata=0xDEADBEEF in cycle 2; no d_ack.
- d_stb and i_stb both asserted in the same cycle after reset: D granted first, then I; check mem_addr order d_addr then i_addr, with d_ack before i_ack.
- d_stb held continuously for 4 writes while i_stb is pending: grant order D,I,D,I,...; i_ack issued after the first d_ack; every write shows mem_we=1 and mem_wdata=d_wdata.
- Memory with 3 wait states: mem_stb stays high for 4 cycles; ack arrives 1 cycle after mem_ack; bus_err stays 0.
- Memory never acks with TIMEOUT=15: after 15 BUSY cycles, mem_stb drops, d_ack=1 with d_rdata=0, bus_err=1, and bus_err persists through later good transactions until rst.
- rst asserted in the second BUSY cycle: the next cycle has all outputs 0 and no ack; a new request after reset completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/load-store requesters, the memory port and mem_port_arbiter.
// master = the arbiter; slave = the requesters and the memory it serves.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) ();
    logic              i_stb;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_stb;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_stb;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              bus_err;

    modport master (
        input  i_stb, i_addr, d_stb, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_stb, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport slave (
        output i_stb, i_addr, d_stb, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_stb, mem_we, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with alternating
// priority on contention, a registered strobe/ack handshake and a hung-memory timeout.
module mem_port_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    grant_t            last_grant_q, grant_d;
    logic              do_grant, do_complete, do_abort;
    logic [7:0]        timeout_cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_stb_q, mem_we_q, bus_err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              i_ack_w, d_ack_w;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        state_d     = state_q;
        grant_d     = last_grant_q;
        do_grant    = 1'b0;
        do_complete = 1'b0;
        do_abort    = 1'b0;
        case (state_q)
            IDLE: begin
                // Data wins a tie unless it also won the previous grant.
                if (bus.d_stb && (!bus.i_stb || last_grant_q == GRANT_I)) begin
                    grant_d  = GRANT_D;
                    do_grant = 1'b1;
                    state_d  = BUSY;
                end else if (bus.i_stb) begin
                    grant_d  = GRANT_I;
                    do_grant = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    do_complete = 1'b1;
                    state_d     = DONE;
                end else if (timeout_cnt_q == TIMEOUT_LAST) begin
                    do_abort = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use <= so every flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= grant_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_cnt_q <= '0;
            rdata_q       <= '0;
            mem_stb_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            bus_err_q     <= 1'b0;
        end else begin
            if (do_grant) begin
                mem_stb_q  <= 1'b1;
                mem_we_q   <= (grant_d == GRANT_D) && bus.d_we;
                mem_addr_q <= (grant_d == GRANT_D) ? bus.d_addr : bus.i_addr;
                if (grant_d == GRANT_D) begin
                    mem_wdata_q <= bus.d_wdata;
                end
            end
            if (do_complete) begin
                mem_stb_q <= 1'b0;
                mem_we_q  <= 1'b0;
                rdata_q   <= bus.mem_rdata;
            end
            if (do_abort) begin
                mem_stb_q <= 1'b0;
                mem_we_q  <= 1'b0;
                rdata_q   <= '0;
                bus_err_q <= 1'b1;
            end
            if (state_q == BUSY && !bus.mem_ack) begin
                timeout_cnt_q <= timeout_cnt_q + 8'd1;
            end else if (state_q == DONE) begin
                timeout_cnt_q <= '0;
            end
        end
    end

    assign i_ack_w       = (state_q == DONE) && (last_grant_q == GRANT_I);
    assign d_ack_w       = (state_q == DONE) && (last_grant_q == GRANT_D);
    assign bus.i_ack     = i_ack_w;
    assign bus.d_ack     = d_ack_w;
    assign bus.i_rdata   = i_ack_w ? rdata_q : '0;
    assign bus.d_rdata   = d_ack_w ? rdata_q : '0;
    assign bus.mem_stb   = mem_stb_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: requesters and memory are modelled at transaction
// level; each cycle the DUT outputs are compared against the model on the falling edge.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks;
    int failures;

    req_t fq[$];
    req_t dq[$];
    int   waits_q[$];
    bit   ack_log[$];
    logic [DATA_W-1:0] mem_arr [logic [ADDR_W-1:0]];

    int   i_gap, d_gap, gap_max;
    bit   rand_waits;
    bit   in_txn, end_next, end_abort, cur_d, last_d, err_model;
    bit   grant_due, due_i, due_d;
    int   busy_n, cur_wait, stb_run, last_run;
    req_t cur;
    logic [DATA_W-1:0] end_rdata;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input logic we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata);
        req_t r;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] addr);
        if (mem_arr.exists(addr)) return mem_arr[addr];
        return {8'hA5, addr};
    endfunction

    function automatic int rand_wait();
        int k = int'($urandom_range(0, 11));
        if (k < 4)   return k;
        if (k < 10)  return 0;
        if (k == 10) return TIMEOUT - 1;
        return NEVER;
    endfunction

    function automatic logic [15:0] log_bits();
        logic [15:0] v = '0;
        foreach (ack_log[k]) v = {v[14:0], ack_log[k]};
        return v;
    endfunction

    function automatic logic [127:0] outs();
        return {bus.i_ack, bus.i_rdata, bus.d_ack, bus.d_rdata, bus.mem_stb, bus.mem_we,
                bus.mem_addr, bus.mem_wdata, bus.bus_err};
    endfunction

    task automatic model_clear();
        fq.delete(); dq.delete(); waits_q.delete(); ack_log.delete();
        in_txn = 0; end_next = 0; end_abort = 0; cur_d = 0; last_d = 0; err_model = 0;
        grant_due = 0; due_i = 0; due_d = 0; busy_n = 0; i_gap = 0; d_gap = 0;
        stb_run = 0; last_run = 0;
        bus.i_stb = 0; bus.i_addr = '0; bus.d_stb = 0; bus.d_we = 0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", outs(), 128'd0);
        rst = 1'b0;
    endtask

    // One clock: check the cycle just completed, then drive memory and requesters.
    task automatic tick();
        logic [DATA_W-1:0] resp;
        bit ended;
        @(negedge clk);
        ended = end_next;
        if (ended && end_abort) err_model = 1'b1;
        chk("bus_err", bus.bus_err, err_model);
        if (ended) begin
            last_run = stb_run;
            chk("mem_stb_after", bus.mem_stb, 0);
            chk("i_ack", {bus.i_ack, bus.i_rdata}, cur_d ? 33'd0 : {1'b1, end_rdata});
            chk("d_ack", {bus.d_ack, bus.d_rdata}, cur_d ? {1'b1, end_rdata} : 33'd0);
            ack_log.push_back(cur_d);
            if (cur_d) begin
                void'(dq.pop_front());
                d_gap = int'($urandom_range(0, gap_max));
            end else begin
                void'(fq.pop_front());
                i_gap = int'($urandom_range(0, gap_max));
            end
            in_txn   = 0;
            end_next = 0;
        end else begin
            chk("no_ack", {bus.i_ack, bus.d_ack, bus.i_rdata, bus.d_rdata}, 0);
            if (in_txn) begin
                busy_n++;
                chk("mem_stb_hold", bus.mem_stb, 1);
                chk("mem_addr_hold", bus.mem_addr, cur.addr);
            end else if (grant_due) begin
                chk("mem_stb_rise", bus.mem_stb, 1);
                cur_d = due_d && (!due_i || !last_d);
                cur   = cur_d ? dq[0] : fq[0];
                chk("mem_addr", bus.mem_addr, cur.addr);
                chk("mem_we", bus.mem_we, cur.we);
                if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wdata);
                last_d   = cur_d;
                in_txn   = 1;
                busy_n   = 1;
                cur_wait = (waits_q.size() != 0) ? waits_q.pop_front()
                                                 : (rand_waits ? rand_wait() : 0);
            end else begin
                chk("mem_stb_idle", bus.mem_stb, 0);
            end
        end
        stb_run = bus.mem_stb ? stb_run + 1 : 0;

        bus.mem_rdata = $urandom;
        bus.mem_ack   = 1'b0;
        if (in_txn) begin
            if (busy_n == cur_wait + 1) begin
                resp = cur.we ? $urandom : rd_val(cur.addr);
                if (cur.we) mem_arr[cur.addr] = cur.wdata;
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = resp;
                end_rdata     = resp;
                end_next      = 1;
                end_abort     = 0;
            end else if (busy_n == TIMEOUT) begin
                end_rdata = '0;
                end_next  = 1;
                end_abort = 1;
            end
        end else begin
            bus.mem_ack = ($urandom_range(0, 3) == 0);
        end

        if (i_gap > 0) begin
            i_gap--;
            bus.i_stb = 1'b0;
        end else begin
            bus.i_stb = (fq.size() != 0);
        end
        bus.i_addr = ADDR_W'($urandom);
        if (bus.i_stb && !(in_txn && !cur_d)) bus.i_addr = fq[0].addr;

        if (d_gap > 0) begin
            d_gap--;
            bus.d_stb = 1'b0;
        end else begin
            bus.d_stb = (dq.size() != 0);
        end
        bus.d_addr  = ADDR_W'($urandom);
        bus.d_wdata = $urandom;
        bus.d_we    = 1'($urandom);
        if (bus.d_stb && !(in_txn && cur_d)) begin
            bus.d_addr  = dq[0].addr;
            bus.d_wdata = dq[0].wdata;
            bus.d_we    = dq[0].we;
        end

        grant_due = !in_txn && !ended && (bus.i_stb || bus.d_stb);
        due_i     = bus.i_stb;
        due_d     = bus.d_stb;
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((fq.size() != 0 || dq.size() != 0 || in_txn || end_next) && n < budget) begin
            tick();
            n++;
        end
        chk("cycle_budget", n < budget, 1);
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        gap_max = 0;
        rand_waits = 0;
        model_clear();

        do_reset();
        mem_arr[24'h000100] = 32'hDEADBEEF;
        fq.push_back(mk(1'b0, 24'h000100, '0));
        waits_q.push_back(0);
        run(50);
        chk("t1_count", ack_log.size(), 1);
        chk("t1_order", log_bits(), 16'h0000);

        do_reset();
        fq.push_back(mk(1'b0, 24'h000400, '0));
        dq.push_back(mk(1'b0, 24'h000800, '0));
        run(50);
        chk("t2_count", ack_log.size(), 2);
        chk("t2_order", log_bits(), 16'b10);

        do_reset();
        for (int k = 0; k < 4; k++) dq.push_back(mk(1'b1, 24'h001000 + 24'(4 * k), $urandom));
        for (int k = 0; k < 3; k++) fq.push_back(mk(1'b0, 24'h002000 + 24'(4 * k), '0));
        run(100);
        chk("t3_count", ack_log.size(), 7);
        chk("t3_order", log_bits(), 16'b1010101);

        do_reset();
        dq.push_back(mk(1'b0, 24'h003000, '0));
        waits_q.push_back(3);
        run(50);
        chk("t4_stb_cycles", last_run, 4);
        chk("t4_bus_err", bus.bus_err, 0);

        do_reset();
        dq.push_back(mk(1'b0, 24'h004000, '0));
        dq.push_back(mk(1'b1, 24'h004004, 32'h12345678));
        dq.push_back(mk(1'b0, 24'h004004, '0));
        waits_q.push_back(NEVER);
        waits_q.push_back(0);
        waits_q.push_back(2);
        run(200);
        chk("t5_count", ack_log.size(), 3);
        chk("t5_bus_err_sticky", bus.bus_err, 1);
        do_reset();

        fq.push_back(mk(1'b0, 24'h000200, '0));
        waits_q.push_back(NEVER);
        tick();
        tick();
        tick();
        rst = 1'b1;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("t6_reset_mid_busy", outs(), 128'd0);
        model_clear();
        rst = 1'b0;
        fq.push_back(mk(1'b0, 24'h000300, '0));
        run(50);
        chk("t6_after_reset", ack_log.size(), 1);

        do_reset();
        gap_max = 3;
        rand_waits = 1;
        for (int k = 0; k < 40; k++) begin
            fq.push_back(mk(1'b0, 24'h005000 + 24'(4 * $urandom_range(0, 7)), '0));
            dq.push_back(mk(1'($urandom), 24'h005000 + 24'(4 * $urandom_range(0, 7)), $urandom));
        end
        run(8000);
        chk("rand_count", ack_log.size(), 80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
